// File: rtl/activation_load_ctrl_if.sv
// Activation-load bus: tile control, the valid/ready activation stream in,
// and the registered write port / mode flags out to the activation store.
//   master : drives start, act_in, act_in_valid, weight_load_done
//   slave  : drives act_in_ready, Activation, Activation_Mem_Address_in,
//            load_mem_done, Cal, busy, tile_done
interface activation_load_ctrl_if #(
  parameter int DATA_W     = 7,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic [DATA_W-1:0]     act_in;
  logic                  act_in_valid;
  logic                  act_in_ready;
  logic                  weight_load_done;
  logic [DATA_W-1:0]     Activation;
  logic [ADDR_WIDTH-1:0] Activation_Mem_Address_in;
  logic                  load_mem_done;
  logic                  Cal;
  logic                  busy;
  logic                  tile_done;

  modport master (
    output start, act_in, act_in_valid, weight_load_done,
    input  act_in_ready, Activation, Activation_Mem_Address_in,
           load_mem_done, Cal, busy, tile_done
  );

  modport slave (
    input  start, act_in, act_in_valid, weight_load_done,
    output act_in_ready, Activation, Activation_Mem_Address_in,
           load_mem_done, Cal, busy, tile_done
  );
endinterface

// File: rtl/activation_load_ctrl.sv
// Write-side sequencer for the activation store of a systolic-array tile.
// Takes SIZE*SIZE activations over a valid/ready stream, writes them
// row-major into the store, waits for the weight loader, then switches the
// store to compute mode and holds Cal for CAL_LEN cycles before a one-cycle
// DONE that rewinds the store and returns to IDLE.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-high
//   bus  - activation_load_ctrl_if.slave (stream in, store write port and
//          mode flags out; see the interface file for the signal list)
module activation_load_ctrl #(
  parameter int SIZE       = 8,
  parameter int MEM_SIZE   = SIZE * SIZE,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int CAL_LEN    = 3 * SIZE,
  parameter int CNT_WIDTH  = $clog2(CAL_LEN + 1),
  parameter int DATA_W     = 7
) (
  input logic                  clk,
  input logic                  rst,
  activation_load_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_W, CAL, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(CAL_LEN - 1);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [CNT_WIDTH-1:0]  cal_cnt;
  logic                  vld_p0;
  logic [DATA_W-1:0]     act_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;

  // Accepted beat: ready is only ever high in LOAD.
  assign vld_p0 = bus.act_in_valid && bus.act_in_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = LOAD;
      LOAD:    if (vld_p0 && (wr_ptr == LAST_ADDR)) state_nx = WAIT_W;
      // At least one cycle here so the last registered word is written
      // while the store is still in load mode.
      WAIT_W:  if (bus.weight_load_done) state_nx = CAL;
      CAL:     if (cal_cnt == LAST_CNT) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      cal_cnt <= '0;
    end else begin
      if ((state == IDLE) && bus.start) wr_ptr <= '0;
      else if (vld_p0)                  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);

      if ((state == WAIT_W) && bus.weight_load_done) cal_cnt <= '0;
      else if (state == CAL)                         cal_cnt <= cal_cnt + CNT_WIDTH'(1);
    end
  end

  // ---- stage p0: registered write port; holds between accepted beats ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_p0  <= '0;
      addr_p0 <= '0;
    end else if (vld_p0) begin
      act_p0  <= bus.act_in;
      addr_p0 <= wr_ptr;
    end
  end

  assign bus.Activation                = act_p0;
  assign bus.Activation_Mem_Address_in = addr_p0;
  assign bus.act_in_ready              = (state == LOAD);
  assign bus.load_mem_done             = (state == CAL) || (state == DONE);
  assign bus.Cal                       = (state == CAL);
  assign bus.tile_done                 = (state == DONE);
  assign bus.busy                      = (state != IDLE);

endmodule
